char_overlay: RTL and testbench
===============================

CHAR_OVERLAY -- requirements
Module: char_overlay

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, glyph ROM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, glyph ROM word width; one word holds 8 horizontal pixels, MSB leftmost.
REQ-003 The block SHALL have parameters CHAR_X, default 100, and CHAR_Y, default 100; these give the top-left pixel of the overlay window.
REQ-004 The block SHALL have parameters CHAR_W, default 32, window width in pixels (multiple of 8), and CHAR_H, default 64, window height in lines.
REQ-005 The block SHALL have parameter FG_COLOR, default 24'hFF0000, RGB888 colour for set glyph bits.
REQ-006 The port list SHALL be:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- overlay_en  input  1  overlay enable request.
- i_vsync  input  1  active-high frame sync.
- i_hsync  input  1  line sync.
- i_de  input  1  active-video qualifier.
- i_data  input  24  RGB888 pixel.
- rom_addr  output  ADDR_WIDTH  glyph ROM read address; the ROM read is combinational.
- rom_data  input  DATA_WIDTH  glyph ROM word for rom_addr, valid in the same cycle.
- o_vsync, o_hsync, o_de  output  1 each  delayed syncs.
- o_data  output  24  overlaid pixel.

Function
REQ-007 x_cnt (12 bit) SHALL increment on each i_de=1 cycle and clear to 0 on any i_de=0 cycle.
- The current pixel's column is the value of x_cnt before the increment.
REQ-008 y_cnt (12 bit) SHALL increment on each i_de 1->0 transition and clear to 0 on an i_vsync 0->1 transition.
- If both occur in the same cycle, the clear wins.
REQ-009 x_cnt and y_cnt SHALL saturate at 4095 and never wrap.
REQ-010 A pixel SHALL be in-window when all of the following hold:
- i_de=1;
- CHAR_X <= column < CHAR_X+CHAR_W;
- CHAR_Y <= y_cnt < CHAR_Y+CHAR_H.
REQ-011 For an in-window pixel at dx = column-CHAR_X and dy = y_cnt-CHAR_Y:
- rom_addr SHALL be dy*(CHAR_W/8) + dx/8, truncated to ADDR_WIDTH;
- the bit index SHALL be 7 - dx%8.
REQ-012 Stage 1 SHALL register rom_addr, the bit index, the in-window flag, the three syncs and i_data.
REQ-013 rom_addr SHALL hold its previous value for pixels outside the window.
REQ-014 Stage 2 SHALL register the outputs:
- o_data = FG_COLOR when (in-window and en_active and rom_data[bit index]=1);
- otherwise o_data = the stage-1 pixel.
REQ-015 All outputs SHALL have a fixed latency of exactly 2 clk cycles from inputs, with syncs and data kept aligned.
REQ-016 en_active SHALL load overlay_en only on an i_vsync 0->1 transition, so overlay state never changes mid-frame.
REQ-017 A window exceeding the frame or 4095 SHALL be clipped silently; pixels outside the frame are never overlaid.

Reset
REQ-018 While rst=1 the block SHALL clear:
- x_cnt, y_cnt, en_active, rom_addr;
- all pipeline registers;
- o_vsync, o_hsync, o_de and o_data.
REQ-019 Reset asserted mid-frame SHALL take effect at the next clk edge.
REQ-020 After reset, overlaying SHALL stay off until the first i_vsync rising edge samples overlay_en=1.

Structure
REQ-021 A shared package SHALL hold:
- the RGB888 pixel width constant (24);
- the counter width (12);
- the default FG_COLOR.
REQ-022 The sync/data delay line SHALL be a sub-module video_delay, parameterised by width and depth (here 27 bits, 2 stages).
REQ-023 The glyph ROM SHALL sit outside this block.

Verification
REQ-024 Disabled overlay: overlay_en=0 with a 640x480 frame -> o_data equals i_data, delayed exactly 2 cycles, for every pixel; syncs aligned.
REQ-025 Single set bit: ROM word 0 = 8'h80, overlay enabled:
- pixel (100,100) -> FG_COLOR;
- pixels (101..107,100) -> pass through;
- rom_addr=0 at (100,100).
REQ-026 Window boundaries with an all-ones ROM:
- (99,100), (132,100), (100,99) and (100,164) -> pass through;
- (131,163) -> FG_COLOR with rom_addr=255.
REQ-027 Mid-frame enable: overlay_en raised at line 120 -> no overlay this frame; overlay begins from the next frame's window.
REQ-028 Reset: rst pulsed for 1 cycle at pixel (110,105):
- next edge: all outputs 0;
- counters restart correctly from the next vsync;
- overlay stays off until the next vsync samples overlay_en=1.
REQ-029 Counter saturation: a 5000-pixel DE line -> x_cnt holds 4095, no wrap, and no spurious overlay at columns 4096+.

Source files
------------

// File: rtl/char_overlay_pkg.sv
// Shared constants and the video bundle type for the character overlay.
package char_overlay_pkg;

    localparam int PIX_W = 24;
    localparam int CNT_W = 12;
    localparam logic [PIX_W-1:0] DEFAULT_FG_COLOR = 24'hFF0000;

    typedef struct packed {
        logic             vsync;
        logic             hsync;
        logic             de;
        logic [PIX_W-1:0] data;
    } video_t;

    localparam int VIDEO_W = $bits(video_t);

endpackage

// File: rtl/video_delay.sv
// Fixed-depth shift register that keeps syncs and pixel data aligned.
module video_delay #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // NOTE: this array is a handful of flops, not a RAM, so clearing it on
    // reset is cheap and guarantees quiet syncs right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/char_overlay.sv
// Overlays a 1-bpp glyph window onto an RGB888 stream with a fixed 2-cycle latency.
module char_overlay
    import char_overlay_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CHAR_X = 100,
    parameter int CHAR_Y = 100,
    parameter int CHAR_W = 32,
    parameter int CHAR_H = 64,
    parameter logic [PIX_W-1:0] FG_COLOR = DEFAULT_FG_COLOR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  overlay_en,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_de,
    input  logic [PIX_W-1:0]      i_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  o_vsync,
    output logic                  o_hsync,
    output logic                  o_de,
    output logic [PIX_W-1:0]      o_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] X0 = CNT_W'(CHAR_X);
    localparam logic [CNT_W-1:0] Y0 = CNT_W'(CHAR_Y);
    localparam int X_END = CHAR_X + CHAR_W;
    localparam int Y_END = CHAR_Y + CHAR_H;

    logic [CNT_W-1:0] x_cnt, y_cnt;
    logic             x_ovf, y_ovf;
    logic             de_prev, vs_prev;
    logic             en_active;
    logic             vs_rise, de_fall;

    assign vs_rise = i_vsync & ~vs_prev;
    assign de_fall = de_prev & ~i_de;

    // x_ovf/y_ovf mark positions past 4095 so a saturated counter can never
    // alias onto a window that reaches the top of the counter range.
    // NOTE: every register here uses <= so all of them sample the pre-edge
    // values; blocking assignments would let later lines see updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            de_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            en_active <= 1'b0;
        end else begin
            de_prev <= i_de;
            vs_prev <= i_vsync;

            if (vs_rise) begin
                en_active <= overlay_en;
            end

            if (!i_de) begin
                x_cnt <= '0;
                x_ovf <= 1'b0;
            end else if (x_cnt == CNT_MAX) begin
                x_ovf <= 1'b1;
            end else begin
                x_cnt <= x_cnt + CNT_ONE;
            end

            if (vs_rise) begin
                y_cnt <= '0;
                y_ovf <= 1'b0;
            end else if (de_fall) begin
                if (y_cnt == CNT_MAX) begin
                    y_ovf <= 1'b1;
                end else begin
                    y_cnt <= y_cnt + CNT_ONE;
                end
            end
        end
    end

    logic                  in_win;
    logic [CNT_W-1:0]      dx, dy;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [2:0]            bit_d;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        in_win = 1'b0;
        dx     = x_cnt - X0;
        dy     = y_cnt - Y0;
        addr_d = ADDR_WIDTH'(dy) * ADDR_WIDTH'(CHAR_W / 8) + ADDR_WIDTH'(dx >> 3);
        bit_d  = ~dx[2:0];
        if (i_de && !x_ovf && !y_ovf
            && int'(x_cnt) >= CHAR_X && int'(x_cnt) < X_END
            && int'(y_cnt) >= CHAR_Y && int'(y_cnt) < Y_END) begin
            in_win = 1'b1;
        end
    end

    logic       win_q;
    logic [2:0] bit_q;
    logic       hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            bit_q    <= '0;
            win_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            win_q <= in_win;
            bit_q <= bit_d;
            if (in_win) begin
                rom_addr <= addr_d;
            end
            hit_q <= win_q & en_active & rom_data[bit_q];
        end
    end

    video_t vid_in, vid_out;

    assign vid_in = '{vsync: i_vsync, hsync: i_hsync, de: i_de, data: i_data};

    video_delay #(
        .WIDTH(VIDEO_W),
        .DEPTH(2)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .din (vid_in),
        .dout(vid_out)
    );

    assign o_vsync = vid_out.vsync;
    assign o_hsync = vid_out.hsync;
    assign o_de    = vid_out.de;
    assign o_data  = hit_q ? FG_COLOR : vid_out.data;

endmodule

// File: tb/tb_char_overlay.sv
// Directed frame-level bench for char_overlay with a per-pixel expectation queue.
module tb_char_overlay;
    import char_overlay_pkg::*;

    localparam logic [23:0] FG = 24'hFF0000;

    logic        clk;
    logic        rst;
    logic        overlay_en;
    logic        i_vsync, i_hsync, i_de;
    logic [23:0] i_data;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        o_vsync, o_hsync, o_de;
    logic [23:0] o_data;

    logic [7:0] rom [256];
    assign rom_data = rom[rom_addr];

    char_overlay dut (
        .clk       (clk),
        .rst       (rst),
        .overlay_en(overlay_en),
        .i_vsync   (i_vsync),
        .i_hsync   (i_hsync),
        .i_de      (i_de),
        .i_data    (i_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .o_vsync   (o_vsync),
        .o_hsync   (o_hsync),
        .o_de      (o_de),
        .o_data    (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic ov_now = 1'b0;

    typedef struct {
        video_t v;
        int     x;
        int     y;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Spec-level pixel model: 4 words per line, MSB is the leftmost pixel.
    function automatic logic [23:0] expect_data(input int x, input int y, input logic [23:0] d);
        int dx, dy;
        logic [7:0] w;
        dx = x - 100;
        dy = y - 100;
        if (ov_now && dx >= 0 && dx < 32 && dy >= 0 && dy < 64) begin
            w = rom[dy*4 + dx/8];
            if (w[7 - dx%8]) return FG;
        end
        return d;
    endfunction

    task automatic drive_cycle(input logic vs, input logic hs, input logic de,
                               input logic [23:0] d, input int x, input int y,
                               input logic r);
        exp_t e;
        video_t got;
        i_vsync = vs;
        i_hsync = hs;
        i_de    = de;
        i_data  = d;
        rst     = r;
        e.v.vsync = vs;
        e.v.hsync = hs;
        e.v.de    = de;
        e.v.data  = de ? expect_data(x, y, d) : d;
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
        if (r) begin
            foreach (exp_q[i]) exp_q[i].v = '0;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            got = '{vsync: o_vsync, hsync: o_hsync, de: o_de, data: o_data};
            check($sformatf("out(%0d,%0d)", e.x, e.y), 32'(got), 32'(e.v));
        end
        if (r) check("rst_rom_addr", 32'(rom_addr), 32'h0);
    endtask

    task automatic run_frame(input logic en_vs, input logic exp_ov, input int en_line,
                             input int long_line, input logic rst_frame,
                             input int ax, input int ay, input int aexp);
        int w;
        logic r;
        overlay_en = en_vs;
        drive_cycle(1, 0, 0, 24'h0, 0, 0, 0);
        drive_cycle(1, 0, 0, 24'h0, 0, 0, 0);
        drive_cycle(0, 0, 0, 24'h0, 0, 0, 0);
        drive_cycle(0, 0, 0, 24'h0, 0, 0, 0);
        ov_now = exp_ov;
        for (int y = 0; y < 166; y++) begin
            if (y == en_line) overlay_en = 1'b1;
            if (y == long_line) w = 5000;
            else if (y >= 98) w = 136;
            else w = 2;
            for (int x = 0; x < w; x++) begin
                r = rst_frame && y == 105 && x == 110;
                drive_cycle(0, 0, 1, 24'({y[11:0], x[11:0]}), x, y, r);
                if (r) ov_now = 1'b0;
                if (y == ay && (x == ax || x == ax + 1))
                    check($sformatf("rom_addr(%0d,%0d)", x, y), 32'(rom_addr), 32'(aexp));
                if (y == long_line && x == w - 1)
                    check("x_cnt_sat", 32'(dut.x_cnt), 32'd4095);
            end
            drive_cycle(0, 1, 0, 24'h0F0F0F, 0, y, 0);
            drive_cycle(0, 1, 0, 24'h0F0F0F, 0, y, 0);
            drive_cycle(0, 0, 0, 24'h0F0F0F, 0, y, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        overlay_en = 1'b0;
        i_vsync = 1'b0;
        i_hsync = 1'b0;
        i_de = 1'b0;
        i_data = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h80;

        repeat (3) drive_cycle(0, 0, 0, 24'h0, 0, 0, 1);
        repeat (2) drive_cycle(0, 0, 0, 24'h0, 0, 0, 0);

        // Overlay disabled: pure 2-cycle pass-through.
        run_frame(0, 0, -1, -1, 0, -1, -1, 0);
        // Single set bit at (100,100), address 0 for the first word.
        run_frame(1, 1, -1, -1, 0, 100, 100, 0);

        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        // Window edges, last address 255 held past the window, 5000-pixel line.
        run_frame(1, 1, -1, 110, 0, 131, 163, 255);
        // Enable raised mid-frame is ignored until the next vsync.
        run_frame(0, 0, 120, -1, 0, -1, -1, 0);
        // Overlay active, then reset at (110,105) kills it for the rest of the frame.
        run_frame(1, 1, -1, -1, 1, -1, -1, 0);
        // Counters and enable recover on the following vsync.
        run_frame(1, 1, -1, -1, 0, 100, 100, 0);

        repeat (3) drive_cycle(0, 0, 0, 24'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
